// File: rtl/hazard_ctrl.sv
// Scoreboard-based hazard controller: tracks in-flight producers past decode,
// drives the D-stage stall, forwarding selects and the mult/div busy counter.
module hazard_ctrl #(
  parameter int STAGES      = 3,
  parameter int AW          = 5,
  parameter int TW          = 4,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        D_valid,
  input  logic [AW-1:0]               D_rs_addr,
  input  logic [AW-1:0]               D_rt_addr,
  input  logic [TW-1:0]               D_rs_Tuse,
  input  logic [TW-1:0]               D_rt_Tuse,
  input  logic [AW-1:0]               D_wr_addr,
  input  logic [TW-1:0]               D_Tnew,
  input  logic                        D_md_start,
  input  logic                        D_md_is_div,
  input  logic                        D_md_use,
  output logic                        stall,
  output logic [$clog2(STAGES+1)-1:0] fwd_rs_sel,
  output logic [$clog2(STAGES+1)-1:0] fwd_rt_sel,
  output logic                        md_busy
);

  localparam int SW   = $clog2(STAGES + 1);
  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  logic [STAGES:1][AW-1:0] r_addr;
  logic [STAGES:1][TW-1:0] r_tnew;
  logic [CW-1:0]           r_md_cnt;

  logic [STAGES:0][TW-1:0] w_tnew_v;
  logic [SW-1:0]           w_rs_sel;
  logic [SW-1:0]           w_rt_sel;
  logic                    w_stall_rs;
  logic                    w_stall_rt;
  logic                    w_stall_md;
  logic                    w_issue;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
    return (v == {TW{1'b0}}) ? {TW{1'b0}} : (v - TW'(1));
  endfunction

  // Scanning oldest to youngest lets the youngest match overwrite older ones.
  function automatic logic [SW-1:0] find_youngest(input logic [AW-1:0] a,
                                                   input logic [STAGES:1][AW-1:0] addrs);
    logic [SW-1:0] sel;
    sel = {SW{1'b0}};
    for (int k = STAGES; k >= 1; k--) begin
      sel = ((a != {AW{1'b0}}) && (addrs[k] == a)) ? SW'(k) : sel;
    end
    return sel;
  endfunction

  // Slot 0 stands for the register file, whose data is always ready.
  assign w_tnew_v = {r_tnew, {TW{1'b0}}};

  // Hazard detection and forwarding select generation.
  always_comb begin
    w_rs_sel   = find_youngest(D_rs_addr, r_addr);
    w_rt_sel   = find_youngest(D_rt_addr, r_addr);
    w_stall_rs = (w_tnew_v[w_rs_sel] > D_rs_Tuse);
    w_stall_rt = (w_tnew_v[w_rt_sel] > D_rt_Tuse);
    w_stall_md = D_valid & D_md_use & md_busy;
  end

  assign stall      = D_valid & (w_stall_rs | w_stall_rt | w_stall_md);
  assign w_issue    = D_valid & ~stall;
  assign fwd_rs_sel = w_rs_sel;
  assign fwd_rt_sel = w_rt_sel;
  assign md_busy    = (r_md_cnt != {CW{1'b0}});

  // Scoreboard shift: a bubble enters E whenever D does not issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= '0;
      r_tnew <= '0;
    end else begin
      r_addr[1] <= w_issue ? D_wr_addr : {AW{1'b0}};
      r_tnew[1] <= w_issue ? sat_dec(D_Tnew) : {TW{1'b0}};
      for (int k = 2; k <= STAGES; k++) begin
        r_addr[k] <= r_addr[k-1];
        r_tnew[k] <= sat_dec(r_tnew[k-1]);
      end
    end
  end

  // Multiply/divide busy counter; a stalled start never reloads it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_md_cnt <= {CW{1'b0}};
    end else if (w_issue && D_md_start) begin
      r_md_cnt <= D_md_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (r_md_cnt != {CW{1'b0}}) begin
      r_md_cnt <= r_md_cnt - CW'(1);
    end else begin
      r_md_cnt <= r_md_cnt;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: stimulus pushes expected D-stage
// responses, a negedge monitor pops and compares them.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       D_valid = 1'b0;
  logic [4:0] D_rs_addr = 5'd0;
  logic [4:0] D_rt_addr = 5'd0;
  logic [3:0] D_rs_Tuse = 4'd7;
  logic [3:0] D_rt_Tuse = 4'd7;
  logic [4:0] D_wr_addr = 5'd0;
  logic [3:0] D_Tnew = 4'd0;
  logic       D_md_start = 1'b0;
  logic       D_md_is_div = 1'b0;
  logic       D_md_use = 1'b0;
  logic       stall;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
  logic       md_busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic       st;
    logic [1:0] rs;
    logic [1:0] rt;
    logic       bz;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  hazard_ctrl #(
    .STAGES(3), .AW(5), .TW(4), .MULT_CYCLES(5), .DIV_CYCLES(10)
  ) dut (
    .clk(clk), .reset_n(reset_n), .D_valid(D_valid),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_rs_Tuse(D_rs_Tuse), .D_rt_Tuse(D_rt_Tuse),
    .D_wr_addr(D_wr_addr), .D_Tnew(D_Tnew),
    .D_md_start(D_md_start), .D_md_is_div(D_md_is_div), .D_md_use(D_md_use),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got {stall,rs,rt,busy}=%b required %b", nm, act, req);
    end
  endtask

  // Monitor: compare every expected response queued for this cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      chk(mon_e.name, {stall, fwd_rs_sel, fwd_rt_sel, md_busy},
          {mon_e.st, mon_e.rs, mon_e.rt, mon_e.bz});
    end
  end

  task automatic drv(input logic v, input logic [4:0] rs, input logic [3:0] rsT,
                     input logic [4:0] rt, input logic [3:0] rtT,
                     input logic [4:0] wr, input logic [3:0] tn,
                     input logic ms, input logic md, input logic mu);
    D_valid = v; D_rs_addr = rs; D_rs_Tuse = rsT; D_rt_addr = rt; D_rt_Tuse = rtT;
    D_wr_addr = wr; D_Tnew = tn; D_md_start = ms; D_md_is_div = md; D_md_use = mu;
  endtask

  task automatic exp_cyc(input string nm, input logic st, input logic [1:0] rs,
                         input logic [1:0] rt, input logic bz);
    exp_t e;
    e.name = nm; e.st = st; e.rs = rs; e.rt = rt; e.bz = bz;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 5'd0, 4'd7, 5'd0, 4'd7, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      exp_cyc("flush", 1'b0, 2'd0, 2'd0, 1'b0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Mid-divide asynchronous reset
    drv(1'b1, 5'd0, 4'd7, 5'd0, 4'd7, 5'd0, 4'd0, 1'b1, 1'b1, 1'b1);
    exp_cyc("div_issue", 1'b0, 2'd0, 2'd0, 1'b0);
    drv(1'b1, 5'd29, 4'd1, 5'd0, 4'd7, 5'd8, 4'd3, 1'b0, 1'b0, 1'b0);
    exp_cyc("lw_under_div", 1'b0, 2'd0, 2'd0, 1'b1);
    drv(1'b1, 5'd8, 4'd7, 5'd8, 4'd7, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("pre_reset", {stall, fwd_rs_sel, fwd_rt_sel, md_busy}, {1'b0, 2'd1, 2'd1, 1'b1});
    reset_n = 1'b0;
    #1;
    chk("async_reset", {stall, fwd_rs_sel, fwd_rt_sel, md_busy}, {1'b0, 2'd0, 2'd0, 1'b0});
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    drv(1'b1, 5'd8, 4'd0, 5'd8, 4'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    exp_cyc("reset_release", 1'b0, 2'd0, 2'd0, 1'b0);
    flush();

    // Load-use
    drv(1'b1, 5'd29, 4'd1, 5'd0, 4'd7, 5'd8, 4'd3, 1'b0, 1'b0, 1'b0);
    exp_cyc("lw", 1'b0, 2'd0, 2'd0, 1'b0);
    drv(1'b1, 5'd8, 4'd1, 5'd10, 4'd1, 5'd9, 4'd2, 1'b0, 1'b0, 1'b0);
    exp_cyc("loaduse_stall", 1'b1, 2'd1, 2'd0, 1'b0);
    exp_cyc("loaduse_fwd", 1'b0, 2'd2, 2'd0, 1'b0);
    flush();

    // Invalid D never stalls but still selects
    drv(1'b1, 5'd29, 4'd1, 5'd0, 4'd7, 5'd8, 4'd3, 1'b0, 1'b0, 1'b0);
    exp_cyc("lw2", 1'b0, 2'd0, 2'd0, 1'b0);
    drv(1'b0, 5'd8, 4'd0, 5'd8, 4'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    exp_cyc("invalid_d", 1'b0, 2'd1, 2'd1, 1'b0);
    flush();

    // Branch after ALU
    drv(1'b1, 5'd0, 4'd1, 5'd0, 4'd7, 5'd8, 4'd2, 1'b0, 1'b0, 1'b0);
    exp_cyc("ori", 1'b0, 2'd0, 2'd0, 1'b0);
    drv(1'b1, 5'd8, 4'd0, 5'd0, 4'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    exp_cyc("beq_stall", 1'b1, 2'd1, 2'd0, 1'b0);
    exp_cyc("beq_fwd", 1'b0, 2'd2, 2'd0, 1'b0);
    flush();

    // Youngest wins
    drv(1'b1, 5'd0, 4'd1, 5'd0, 4'd7, 5'd8, 4'd2, 1'b0, 1'b0, 1'b0);
    exp_cyc("ori_a", 1'b0, 2'd0, 2'd0, 1'b0);
    exp_cyc("ori_b", 1'b0, 2'd0, 2'd0, 1'b0);
    drv(1'b1, 5'd8, 4'd1, 5'd8, 4'd1, 5'd1, 4'd2, 1'b0, 1'b0, 1'b0);
    exp_cyc("youngest", 1'b0, 2'd1, 2'd1, 1'b0);
    flush();

    // $0 never matches
    drv(1'b1, 5'd0, 4'd1, 5'd0, 4'd7, 5'd0, 4'd2, 1'b0, 1'b0, 1'b0);
    exp_cyc("ori_r0", 1'b0, 2'd0, 2'd0, 1'b0);
    drv(1'b1, 5'd0, 4'd0, 5'd0, 4'd0, 5'd1, 4'd2, 1'b0, 1'b0, 1'b0);
    exp_cyc("r0_src", 1'b0, 2'd0, 2'd0, 1'b0);
    flush();

    // Divide then mflo
    drv(1'b1, 5'd0, 4'd7, 5'd0, 4'd7, 5'd0, 4'd0, 1'b1, 1'b1, 1'b1);
    exp_cyc("div", 1'b0, 2'd0, 2'd0, 1'b0);
    drv(1'b1, 5'd0, 4'd7, 5'd0, 4'd7, 5'd2, 4'd2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) exp_cyc("mflo_stall", 1'b1, 2'd0, 2'd0, 1'b1);
    exp_cyc("mflo_accept", 1'b0, 2'd0, 2'd0, 1'b0);
    flush();

    // Mult followed by a stalled mult that must not reload the counter
    drv(1'b1, 5'd0, 4'd7, 5'd0, 4'd7, 5'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    exp_cyc("mult", 1'b0, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) exp_cyc("mult2_stall", 1'b1, 2'd0, 2'd0, 1'b1);
    exp_cyc("mult2_accept", 1'b0, 2'd0, 2'd0, 1'b0);
    drv(1'b0, 5'd0, 4'd7, 5'd0, 4'd7, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) exp_cyc("mult2_busy", 1'b0, 2'd0, 2'd0, 1'b1);
    exp_cyc("mult2_done", 1'b0, 2'd0, 2'd0, 1'b0);
    flush();

    // Combined md and data hazard
    drv(1'b1, 5'd0, 4'd7, 5'd0, 4'd7, 5'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    exp_cyc("cmb_mult", 1'b0, 2'd0, 2'd0, 1'b0);
    drv(1'b1, 5'd29, 4'd1, 5'd0, 4'd7, 5'd8, 4'd3, 1'b0, 1'b0, 1'b0);
    exp_cyc("cmb_lw", 1'b0, 2'd0, 2'd0, 1'b1);
    drv(1'b1, 5'd8, 4'd0, 5'd0, 4'd7, 5'd3, 4'd2, 1'b0, 1'b0, 1'b1);
    exp_cyc("cmb_s1", 1'b1, 2'd1, 2'd0, 1'b1);
    exp_cyc("cmb_s2", 1'b1, 2'd2, 2'd0, 1'b1);
    exp_cyc("cmb_s3", 1'b1, 2'd3, 2'd0, 1'b1);
    exp_cyc("cmb_s4", 1'b1, 2'd0, 2'd0, 1'b1);
    exp_cyc("cmb_go", 1'b0, 2'd0, 2'd0, 1'b0);
    flush();

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
